reg_file: RTL



---
 rtl/mips_pkg.sv | 22 ++
 rtl/reg_file_rd_port.sv | 36 +++
 rtl/reg_file.sv | 94 +++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the single-cycle MIPS datapath.
// Holds default widths, architectural register indices, register-file reset
// values and the ALU operation encodings used by the execute stage.
package mips_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  localparam int REG_ZERO = 0;
  localparam int REG_GP   = 28;
  localparam int REG_SP   = 29;
  localparam int REG_RA   = 31;

  localparam logic [31:0] SP_RESET_DEF = 32'h0000_03FC;
  localparam logic [31:0] GP_RESET_DEF = 32'h0000_1800;

  localparam logic [2:0] ALUOP_AND = 3'd0;
  localparam logic [2:0] ALUOP_OR  = 3'd1;
  localparam logic [2:0] ALUOP_ADD = 3'd2;
  localparam logic [2:0] ALUOP_SUB = 3'd6;

endpackage

// File: rtl/reg_file_rd_port.sv
// One combinational read port of the register file.
// Selects an entry by index, forces index 0 to read zero and, when
// REGFILE_BYPASS_EN is defined, forwards the write data of a same-cycle
// write to the same index.
module reg_file_rd_port
  import mips_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NREG   = 2 ** ADDR_W
) (
  input  logic [NREG-1:0][DATA_W-1:0] regs,
  input  logic [ADDR_W-1:0]           rd_addr,
`ifdef REGFILE_BYPASS_EN
  input  logic                        rst_n,
  input  logic                        we,
  input  logic [ADDR_W-1:0]           wa,
  input  logic [DATA_W-1:0]           wd,
`endif
  output logic [DATA_W-1:0]           rd_data
);

  // Zero register first, then (optionally) forward a live write, else storage.
  always_comb begin
    rd_data = regs[rd_addr];
    if (rd_addr == '0) begin
      rd_data = '0;
    end
`ifdef REGFILE_BYPASS_EN
    else if (rst_n && we && (wa != '0) && (wa == rd_addr)) begin
      rd_data = wd;
    end
`endif
  end

endmodule

// File: rtl/reg_file.sv
// 32-entry general-purpose register file for the single-cycle MIPS datapath.
// Two operand read ports (rs -> ALU a, rt -> ALU b path), one debug read port
// and one write-back port. Reads are combinational; writes land on the rising
// edge. Reset is synchronous and active-low and preloads $gp and $sp.
// Optional macro REGFILE_BYPASS_EN enables write-through forwarding on reads.
module reg_file
  import mips_pkg::*;
#(
  parameter int                DATA_W   = DATA_W_DEF,
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter logic [DATA_W-1:0] SP_RESET = SP_RESET_DEF,
  parameter logic [DATA_W-1:0] GP_RESET = GP_RESET_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ra_addr,
  output logic [DATA_W-1:0] ra_data,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] rb_data,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int NREG = 2 ** ADDR_W;

  // Entry 0 has no storage; it is hard-wired to zero in the read view.
  logic [DATA_W-1:0]           regs_q [1:NREG-1];
  logic [NREG-1:0][DATA_W-1:0] regs_view;

  // Reset preloads $gp/$sp and clears the rest; otherwise accept write-back.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 1; i < NREG; i++) begin
        if (i == REG_GP) begin
          regs_q[i] <= GP_RESET;
        end else if (i == REG_SP) begin
          regs_q[i] <= SP_RESET;
        end else begin
          regs_q[i] <= '0;
        end
      end
    end else if (we && (wa != '0)) begin
      regs_q[wa] <= wd;
    end
  end

  // Flatten storage into one vector the read ports can index, with entry 0 = 0.
  always_comb begin
    regs_view[0] = '0;
    for (int i = 1; i < NREG; i++) begin
      regs_view[i] = regs_q[i];
    end
  end

  reg_file_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREG(NREG)) u_port_a (
    .regs    (regs_view),
    .rd_addr (ra_addr),
`ifdef REGFILE_BYPASS_EN
    .rst_n   (rst_n),
    .we      (we),
    .wa      (wa),
    .wd      (wd),
`endif
    .rd_data (ra_data)
  );

  reg_file_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREG(NREG)) u_port_b (
    .regs    (regs_view),
    .rd_addr (rb_addr),
`ifdef REGFILE_BYPASS_EN
    .rst_n   (rst_n),
    .we      (we),
    .wa      (wa),
    .wd      (wd),
`endif
    .rd_data (rb_data)
  );

  reg_file_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREG(NREG)) u_port_dbg (
    .regs    (regs_view),
    .rd_addr (dbg_addr),
`ifdef REGFILE_BYPASS_EN
    .rst_n   (rst_n),
    .we      (we),
    .wa      (wa),
    .wd      (wd),
`endif
    .rd_data (dbg_data)
  );

endmodule
